demux_stream_router: RTL and testbench
======================================

// Module: demux_stream_router
//
// PURPOSE
//   Inverse of the mux primitive: one valid/ready input stream is steered to one of
//   N_OUT output channels chosen by a per-beat select.
//   Each channel owns a one-entry output register, so a stalled channel never blocks
//   beats bound for other channels. Beats whose select is out of range are dropped
//   and counted.
//   Sits between a single producer and N_OUT independent consumers.
//
// PARAMETERS
//   WIDTH   8   data width of every beat
//   N_OUT   3   number of output channels, >= 2; need not be a power of 2
//   SEL_W   $clog2(N_OUT) (localparam)   width of in_sel
//
// PORTS
//   clk        in   1             clock; all state changes on posedge
//   rst        in   1             synchronous reset, active-high
//   in_valid   in   1             producer offers a beat
//   in_ready   out  1             router accepts the beat this cycle
//   in_data    in   WIDTH         beat payload
//   in_sel     in   SEL_W         destination channel index
//   out_valid  out  N_OUT         bit k: channel k register holds a beat
//   out_ready  in   N_OUT         bit k: consumer k takes the beat this cycle
//   out_data   out  N_OUT*WIDTH   channel k payload at bits [k*WIDTH +: WIDTH]
//   drop_err   out  1             one-cycle pulse: an out-of-range beat was dropped
//   drop_cnt   out  8             saturating count of dropped beats
//
// BEHAVIOUR
//   - Reset (rst=1 at posedge): out_valid=0, out_data=0, drop_err=0, drop_cnt=0.
//     Takes precedence over any handshake in the same cycle. Beats in flight are lost.
//   - in_ready is combinational from in_sel, out_valid and out_ready.
//     When in_sel < N_OUT: in_ready = !out_valid[in_sel] | out_ready[in_sel].
//     When in_sel >= N_OUT: in_ready = 1. The beat is discarded.
//     in_ready is 0 while rst=1.
//   - Accept: in_valid & in_ready at posedge.
//     Valid sel: channel in_sel loads in_data and sets out_valid.
//     Invalid sel: drop_err=1 for the next cycle.
//     drop_cnt increments and saturates at 8'hFF; drop_err still pulses at saturation.
//   - Pop: out_valid[k] & out_ready[k] at posedge clears out_valid[k].
//     The data register keeps its last value.
//   - Push and pop on the same channel in the same cycle: the register reloads and
//     out_valid stays 1. One beat/cycle throughput per channel.
//   - A pop on channel j and a push to channel k != j in the same cycle are independent.
//   - Latency: an accepted beat is visible on out_valid/out_data the next cycle.
//   - Stability: while out_valid[k] & !out_ready[k], out_data[k] and out_valid[k] hold.
//   - No reordering within a channel. No beat is duplicated.
//     in_data is ignored when in_valid=0.
//   - Consumers may assert out_ready while out_valid=0; this has no effect.
//
// TESTING
//   1 Reset: rst=1 for 2 cycles with in_valid=1, sel=0 -> out_valid=000, drop_cnt=0,
//     in_ready=0.
//   2 Routing: send A5 sel0, 3C sel1, 7E sel2 with all out_ready=1 -> each lands on its
//     channel 1 cycle after acceptance; other channels stay invalid.
//   3 Backpressure: out_ready[1]=0, send 11 sel1, then 22 sel1 -> second beat stalls
//     (in_ready=0) and out_data[1]=11 holds. Raise out_ready[1] -> 11 pops and 22 loads
//     the same cycle.
//   4 Isolation: channel 0 full and stalled, send 55 sel2 -> accepted immediately;
//     channel 0 is undisturbed.
//   5 Drop: sel=3 with N_OUT=3, four beats -> in_ready=1, no out_valid, drop_err pulses
//     4 times, drop_cnt=4. After 300 drops, drop_cnt=FF.
//   6 Streaming: 100 random beats with random sel and random out_ready -> scoreboard
//     per-channel order intact, no loss or duplication. Channel with out_ready held at 1
//     sustains 1 beat/cycle. Reset mid-stream clears all channels.

Source files
------------

// File: rtl/demux_stream_router.sv
// demux_stream_router: steers one valid/ready stream to one of N_OUT channels, each
// backed by its own one-entry output register; out-of-range selects are dropped and counted.
module demux_stream_router #(
  parameter int WIDTH = 8,
  parameter int N_OUT = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(N_OUT)-1:0] in_sel,
  output logic [N_OUT-1:0]         out_valid,
  input  logic [N_OUT-1:0]         out_ready,
  output logic [N_OUT*WIDTH-1:0]   out_data,
  output logic                     drop_err,
  output logic [7:0]               drop_cnt
);

  localparam int SEL_W = $clog2(N_OUT);
  // One extra bit so the range compare also works when N_OUT is a power of two.
  localparam logic [SEL_W:0] LP_N_OUT = (SEL_W + 1)'(N_OUT);

  logic [N_OUT-1:0]            r_valid;
  logic [N_OUT-1:0][WIDTH-1:0] r_data;
  logic                        r_drop_err;
  logic [7:0]                  r_drop_cnt;

  logic             w_sel_ok;
  logic [N_OUT-1:0] w_hit;
  logic [N_OUT-1:0] w_slot_free;
  logic             w_ready;
  logic             w_accept;
  logic             w_drop;

  // Select decode: range check plus one-hot channel hit.
  always_comb begin
    w_sel_ok = ({1'b0, in_sel} < LP_N_OUT);
    w_hit    = {N_OUT{1'b0}};
    for (int k = 0; k < N_OUT; k++) begin
      w_hit[k] = w_sel_ok && (in_sel == SEL_W'(k));
    end
  end

  assign w_slot_free = ~r_valid | out_ready;

  // Input handshake: a channel slot is free when empty or being drained this cycle.
  always_comb begin
    w_ready = 1'b0;
    if (rst) begin
      w_ready = 1'b0;
    end else if (w_sel_ok) begin
      w_ready = |(w_hit & w_slot_free);
    end else begin
      w_ready = 1'b1;
    end
  end

  assign w_accept = in_valid & w_ready;
  assign w_drop   = w_accept & ~w_sel_ok;

  // Per-channel output registers: a push wins over a pop on the same channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= {N_OUT{1'b0}};
      r_data  <= {(N_OUT*WIDTH){1'b0}};
    end else begin
      for (int k = 0; k < N_OUT; k++) begin
        if (w_accept && w_hit[k]) begin
          r_valid[k] <= 1'b1;
          r_data[k]  <= in_data;
        end else if (out_ready[k]) begin
          r_valid[k] <= 1'b0;
        end
      end
    end
  end

  // Drop pulse and saturating drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_err <= 1'b0;
      r_drop_cnt <= 8'h00;
    end else begin
      r_drop_err <= w_drop;
      if (w_drop && (r_drop_cnt != 8'hFF)) begin
        r_drop_cnt <= r_drop_cnt + 8'h01;
      end
    end
  end

  assign in_ready  = w_ready;
  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign drop_err  = r_drop_err;
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_demux_stream_router.sv
// Bench for demux_stream_router: directed vectors, per-channel scoreboard queues
// filled by an issue tracker and drained by an independent output monitor.
module tb_demux_stream_router;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic [2:0]  out_valid;
  logic [2:0]  out_ready;
  logic [23:0] out_data;
  logic        drop_err;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int errors = 0;

  logic [7:0] q [3][$];
  logic [2:0] pushed_now = 3'b000;
  logic       armed = 1'b0;
  logic       m_armed = 1'b0;
  logic       exp_err = 1'b0;
  logic [7:0] exp_cnt = 8'h00;

  demux_stream_router #(.WIDTH(8), .N_OUT(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .drop_err (drop_err),
    .drop_cnt (drop_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] chan(input int k);
    return out_data[k*8 +: 8];
  endfunction

  // Drive inputs just after the falling edge, return 1 time unit later.
  task automatic step(input logic v, input logic [1:0] s, input logic [7:0] d, input logic [2:0] r);
    @(negedge clk);
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
    #1;
  endtask

  // Issue tracker: predicts in_ready and drop outputs, pushes accepted beats.
  initial begin : tracker
    logic exp_rdy;
    logic acc;
    int   s;
    forever begin
      @(negedge clk);
      #2;
      s = int'(in_sel);
      if (rst) exp_rdy = 1'b0;
      else if (s >= 3) exp_rdy = 1'b1;
      else exp_rdy = (q[s].size() == 0) || out_ready[s];
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      if (armed) begin
        chk("drop_err", 32'(drop_err), 32'(exp_err));
        chk("drop_cnt", 32'(drop_cnt), 32'(exp_cnt));
      end
      pushed_now = 3'b000;
      if (rst) begin
        exp_err = 1'b0;
        exp_cnt = 8'h00;
        armed   = 1'b1;
      end else begin
        acc     = in_valid && exp_rdy;
        exp_err = acc && (s >= 3);
        if (exp_err && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'h01;
        if (acc && s < 3) begin
          q[s].push_back(in_data);
          pushed_now[s] = 1'b1;
        end
      end
    end
  end

  // Output monitor: checks presented beats against queue heads and pops on handshake.
  initial begin : monitor
    forever begin
      @(negedge clk);
      #3;
      if (m_armed) begin
        for (int k = 0; k < 3; k++) begin
          int occ;
          occ = q[k].size() - (pushed_now[k] ? 1 : 0);
          chk($sformatf("out_valid%0d", k), 32'(out_valid[k]), 32'(occ > 0));
          if (out_valid[k] && occ > 0) begin
            chk($sformatf("out_data%0d", k), 32'(chan(k)), 32'(q[k][0]));
            if (out_ready[k] && !rst) void'(q[k].pop_front());
          end
        end
      end
      if (rst) begin
        for (int k = 0; k < 3; k++) q[k].delete();
        m_armed = 1'b1;
      end
    end
  end

  initial begin : stim
    int pulses;
    int waits;
    logic [1:0] s;
    logic [7:0] d;
    rst = 1'b1; in_valid = 1'b1; in_sel = 2'd0; in_data = 8'hA5; out_ready = 3'b000;

    // Reset with a beat offered
    @(negedge clk); #1; chk("rst_in_ready_a", 32'(in_ready), 32'd0);
    @(negedge clk); #1; chk("rst_in_ready_b", 32'(in_ready), 32'd0);
    @(negedge clk); rst = 1'b0; in_valid = 1'b0; #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("rst_drop_err", 32'(drop_err), 32'd0);

    // Routing
    step(1'b1, 2'd0, 8'hA5, 3'b111);
    step(1'b1, 2'd1, 8'h3C, 3'b111);
    chk("route_v0", 32'(out_valid), 32'h1); chk("route_d0", 32'(chan(0)), 32'hA5);
    step(1'b1, 2'd2, 8'h7E, 3'b111);
    chk("route_v1", 32'(out_valid), 32'h2); chk("route_d1", 32'(chan(1)), 32'h3C);
    step(1'b0, 2'd0, 8'h00, 3'b111);
    chk("route_v2", 32'(out_valid), 32'h4); chk("route_d2", 32'(chan(2)), 32'h7E);
    step(1'b0, 2'd0, 8'h00, 3'b111);
    chk("route_idle", 32'(out_valid), 32'h0);

    // Backpressure on channel 1
    step(1'b1, 2'd1, 8'h11, 3'b101);
    chk("bp_first_rdy", 32'(in_ready), 32'd1);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 2'd1, 8'h22, 3'b101);
      chk("bp_stall_rdy", 32'(in_ready), 32'd0);
      chk("bp_hold_data", 32'(chan(1)), 32'h11);
      chk("bp_hold_valid", 32'(out_valid[1]), 32'd1);
    end
    step(1'b1, 2'd1, 8'h22, 3'b111);
    chk("bp_release_rdy", 32'(in_ready), 32'd1);
    step(1'b0, 2'd0, 8'h00, 3'b101);
    chk("bp_reload_valid", 32'(out_valid[1]), 32'd1);
    chk("bp_reload_data", 32'(chan(1)), 32'h22);
    step(1'b0, 2'd0, 8'h00, 3'b111);
    step(1'b0, 2'd0, 8'h00, 3'b111);
    chk("bp_drained", 32'(out_valid), 32'h0);

    // Isolation: channel 0 stalled, channel 2 still flows
    step(1'b1, 2'd0, 8'h99, 3'b110);
    step(1'b1, 2'd2, 8'h55, 3'b110);
    chk("iso_rdy", 32'(in_ready), 32'd1);
    step(1'b0, 2'd0, 8'h00, 3'b110);
    chk("iso_valid", 32'(out_valid), 32'h5);
    chk("iso_d2", 32'(chan(2)), 32'h55); chk("iso_d0", 32'(chan(0)), 32'h99);
    step(1'b0, 2'd0, 8'h00, 3'b110);
    chk("iso_valid_b", 32'(out_valid), 32'h1); chk("iso_d0_b", 32'(chan(0)), 32'h99);
    step(1'b0, 2'd0, 8'h00, 3'b111);
    step(1'b0, 2'd0, 8'h00, 3'b111);
    chk("iso_drained", 32'(out_valid), 32'h0);

    // Drops
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 2'd3, 8'hD0 + 8'(i), 3'b111);
      chk("drop_rdy", 32'(in_ready), 32'd1);
      if (i > 0) pulses += int'(drop_err);
    end
    step(1'b0, 2'd0, 8'h00, 3'b111);
    pulses += int'(drop_err);
    chk("drop_no_valid", 32'(out_valid), 32'h0);
    chk("drop_cnt4", 32'(drop_cnt), 32'd4);
    step(1'b0, 2'd0, 8'h00, 3'b111);
    pulses += int'(drop_err);
    chk("drop_pulses", 32'(pulses), 32'd4);
    chk("drop_err_low", 32'(drop_err), 32'd0);
    for (int i = 0; i < 296; i++) step(1'b1, 2'd3, 8'(i), 3'b000);
    step(1'b0, 2'd0, 8'h00, 3'b111);
    chk("drop_sat", 32'(drop_cnt), 32'hFF);
    step(1'b1, 2'd3, 8'h01, 3'b111);
    step(1'b0, 2'd0, 8'h00, 3'b111);
    chk("drop_sat_pulse", 32'(drop_err), 32'd1);
    chk("drop_sat_hold", 32'(drop_cnt), 32'hFF);

    // Streaming with random select and random backpressure
    for (int i = 0; i < 100; i++) begin
      s = 2'($urandom_range(0, 3));
      d = 8'($urandom);
      step(1'b1, s, d, 3'($urandom_range(0, 7)));
      waits = 0;
      while (!in_ready && waits < 50) begin
        step(1'b1, s, d, 3'($urandom_range(0, 7)));
        waits++;
      end
      chk("stream_accept", 32'(in_ready), 32'd1);
    end
    repeat (3) step(1'b0, 2'd0, 8'h00, 3'b111);

    // Full throughput on channel 0
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 2'd0, 8'h80 + 8'(i), 3'b001);
      chk("tput_rdy", 32'(in_ready), 32'd1);
      if (i > 0) chk("tput_data", 32'(chan(0)), 32'(8'h80 + 8'(i - 1)));
    end
    step(1'b0, 2'd0, 8'h00, 3'b111);

    // Reset mid-stream with all channels full
    step(1'b1, 2'd0, 8'hA1, 3'b000);
    step(1'b1, 2'd1, 8'hB2, 3'b000);
    step(1'b1, 2'd2, 8'hC3, 3'b000);
    step(1'b0, 2'd0, 8'h00, 3'b000);
    chk("mid_full", 32'(out_valid), 32'h7);
    @(negedge clk); rst = 1'b1; in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h5A; #1;
    chk("mid_rst_rdy", 32'(in_ready), 32'd0);
    @(negedge clk); rst = 1'b0; in_valid = 1'b0; out_ready = 3'b111; #1;
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_data", 32'(out_data), 32'h0);

    repeat (4) step(1'b0, 2'd0, 8'h00, 3'b111);
    for (int k = 0; k < 3; k++) chk($sformatf("q_empty%0d", k), 32'(q[k].size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
